// File: rtl/calc_instr_feeder.sv
// Byte-stream feeder for the cached calculator: buffers handshaked bytes in a FIFO and
// turns each one into a cache-load cycle or an N-cycle execute run on mode/opCode/value.
module calc_instr_feeder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CACHE_MAX  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       cacheFull,
  output logic       mode,
  output logic [2:0] opCode,
  output logic [3:0] value,
  output logic [5:0] loaded_cnt,
  output logic [7:0] reject_cnt,
  output logic [7:0] drop_cnt,
  output logic       run_done,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [5:0] CMAX = 6'(CACHE_MAX);

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_full, fifo_empty, push, pop;
  logic [7:0]    head;

  state_t        state_q;
  logic [6:0]    rem_q;
  logic          mode_q, run_done_q;
  logic [2:0]    opcode_q;
  logic [3:0]    value_q;
  logic [5:0]    loaded_q;
  logic [7:0]    reject_q, drop_q;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign in_ready   = !fifo_full && !reset;
  assign push       = in_valid && in_ready;
  // The FSM only consumes in IDLE, so a byte written this edge is seen no earlier than the next.
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      mode_q     <= 1'b0;
      opcode_q   <= 3'b111;
      value_q    <= 4'd0;
      run_done_q <= 1'b0;
      loaded_q   <= '0;
      reject_q   <= '0;
      drop_q     <= '0;
    end else begin
      // Idle pattern (invalid opcode) unless a load or run cycle overrides it below.
      mode_q     <= 1'b0;
      opcode_q   <= 3'b111;
      value_q    <= 4'd0;
      run_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (head[7]) begin
              if (head[6:0] != 7'd0) begin
                state_q    <= RUN;
                rem_q      <= head[6:0];
                mode_q     <= 1'b1;
                run_done_q <= (head[6:0] == 7'd1);
              end
            end else if (head[5:4] == 2'b11) begin
              reject_q <= sat_inc8(reject_q);
            end else if ((loaded_q == CMAX) || cacheFull) begin
              // Discard rather than stall so a queued run behind it is never blocked.
              drop_q <= sat_inc8(drop_q);
            end else begin
              opcode_q <= head[6:4];
              value_q  <= head[3:0];
              loaded_q <= loaded_q + 6'd1;
            end
          end
        end
        RUN: begin
          // rem_q counts the mode=1 cycle currently on the outputs plus those still to come.
          if (rem_q == 7'd1) begin
            state_q <= IDLE;
          end else begin
            rem_q      <= rem_q - 7'd1;
            mode_q     <= 1'b1;
            run_done_q <= (rem_q == 7'd2);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mode       = mode_q;
  assign opCode     = opcode_q;
  assign value      = value_q;
  assign run_done   = run_done_q;
  assign loaded_cnt = loaded_q;
  assign reject_cnt = reject_q;
  assign drop_cnt   = drop_q;
  assign busy       = !fifo_empty || (state_q == RUN);

endmodule

// File: tb/tb_calc_instr_feeder.sv
// Directed bench for calc_instr_feeder: a table of single-byte decodes plus hand-written
// sequences for back-to-back run, cache saturation, FIFO backpressure and reset mid-run.
module tb_calc_instr_feeder;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, cacheFull, mode, run_done, busy;
  logic [7:0] in_data, reject_cnt, drop_cnt;
  logic [2:0] opCode;
  logic [3:0] value;
  logic [5:0] loaded_cnt;

  logic       cf_force;
  int         calc_cnt = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  calc_instr_feeder #(.FIFO_DEPTH(8), .CACHE_MAX(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cacheFull(cacheFull), .mode(mode), .opCode(opCode), .value(value),
    .loaded_cnt(loaded_cnt), .reject_cnt(reject_cnt), .drop_cnt(drop_cnt),
    .run_done(run_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Minimal calculator cache: counts valid load cycles it samples, full at 32 entries.
  always @(posedge clk) begin
    if (reset) calc_cnt <= 0;
    else if (!mode && opCode[1:0] != 2'b11 && calc_cnt < 32) calc_cnt <= calc_cnt + 1;
  end
  assign cacheFull = cf_force || (calc_cnt >= 32);

  typedef struct {
    logic [7:0] data;
    logic       cf;
    logic [8:0] outs;   // {mode, opCode, value, run_done}
    logic [5:0] ld;
    logic [7:0] rj;
    logic [7:0] dp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; cf_force = 1'b0; in_data = 8'h00;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    for (int t = 0; t < 300 && !in_ready; t++) @(negedge clk);
    check("push_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int mcnt, issues, got, k;
    logic ready_ok, done_seen;

    vecs[0]  = '{8'h05, 1'b0, {1'b0, 3'd0, 4'h5, 1'b0}, 6'd1, 8'd0, 8'd0};
    vecs[1]  = '{8'h3A, 1'b0, {1'b0, 3'd7, 4'h0, 1'b0}, 6'd1, 8'd1, 8'd0};
    vecs[2]  = '{8'h72, 1'b0, {1'b0, 3'd7, 4'h0, 1'b0}, 6'd1, 8'd2, 8'd0};
    vecs[3]  = '{8'h1F, 1'b0, {1'b0, 3'd1, 4'hF, 1'b0}, 6'd2, 8'd2, 8'd0};
    vecs[4]  = '{8'h6C, 1'b0, {1'b0, 3'd6, 4'hC, 1'b0}, 6'd3, 8'd2, 8'd0};
    vecs[5]  = '{8'h80, 1'b0, {1'b0, 3'd7, 4'h0, 1'b0}, 6'd3, 8'd2, 8'd0};
    vecs[6]  = '{8'h51, 1'b1, {1'b0, 3'd7, 4'h0, 1'b0}, 6'd3, 8'd2, 8'd1};
    vecs[7]  = '{8'h27, 1'b0, {1'b0, 3'd2, 4'h7, 1'b0}, 6'd4, 8'd2, 8'd1};
    vecs[8]  = '{8'h81, 1'b0, {1'b1, 3'd7, 4'h0, 1'b1}, 6'd4, 8'd2, 8'd1};
    vecs[9]  = '{8'h45, 1'b0, {1'b0, 3'd4, 4'h5, 1'b0}, 6'd5, 8'd2, 8'd1};
    vecs[10] = '{8'h37, 1'b0, {1'b0, 3'd7, 4'h0, 1'b0}, 6'd5, 8'd3, 8'd1};

    // Reset state
    reset = 1'b1; in_valid = 1'b0; cf_force = 1'b0; in_data = 8'h00;
    @(negedge clk); @(negedge clk);
    check("rst_ready_low", {31'd0, in_ready}, 32'd0);
    check("rst_outs", {23'd0, mode, opCode, value, run_done}, {23'd0, 1'b0, 3'd7, 4'd0, 1'b0});
    check("rst_counts", {10'd0, loaded_cnt, reject_cnt, drop_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready_high", {31'd0, in_ready}, 32'd1);

    // Table: one byte at a time into an empty FIFO, outputs checked on the issue cycle
    for (int i = 0; i < 11; i++) begin
      cf_force = vecs[i].cf;
      push(vecs[i].data);
      @(negedge clk);
      check($sformatf("vec%0d_outs", i), {23'd0, mode, opCode, value, run_done},
            {23'd0, vecs[i].outs});
      check($sformatf("vec%0d_counts", i), {10'd0, loaded_cnt, reject_cnt, drop_cnt},
            {10'd0, vecs[i].ld, vecs[i].rj, vecs[i].dp});
      cf_force = 1'b0;
    end
    @(negedge clk);
    check("table_busy", {31'd0, busy}, 32'd0);

    // Load 0x05 then run 3 back-to-back
    do_reset();
    in_valid = 1'b1; in_data = 8'h05;
    @(negedge clk);
    in_data = 8'h83;
    @(negedge clk);
    in_valid = 1'b0;
    check("seq2_load", {23'd0, mode, opCode, value, run_done}, {23'd0, 1'b0, 3'd0, 4'd5, 1'b0});
    @(negedge clk);
    check("seq2_run1", {23'd0, mode, opCode, value, run_done}, {23'd0, 1'b1, 3'd7, 4'd0, 1'b0});
    @(negedge clk);
    check("seq2_run2", {23'd0, mode, opCode, value, run_done}, {23'd0, 1'b1, 3'd7, 4'd0, 1'b0});
    @(negedge clk);
    check("seq2_run3", {23'd0, mode, opCode, value, run_done}, {23'd0, 1'b1, 3'd7, 4'd0, 1'b1});
    @(negedge clk);
    check("seq2_after", {23'd0, mode, opCode, value, run_done}, {23'd0, 1'b0, 3'd7, 4'd0, 1'b0});
    check("seq2_loaded", {26'd0, loaded_cnt}, 32'd1);
    check("seq2_busy", {31'd0, busy}, 32'd0);

    // 34 loads: the cache saturates at 32, the remaining two are dropped
    do_reset();
    issues = 0; ready_ok = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 34; i++) begin
      in_data = 8'h01;
      if (!in_ready) ready_ok = 1'b0;
      @(negedge clk);
      if (!mode && opCode == 3'd0 && value == 4'd1) issues++;
    end
    in_valid = 1'b0;
    for (int t = 0; t < 100 && busy; t++) begin
      @(negedge clk);
      if (!mode && opCode == 3'd0 && value == 4'd1) issues++;
    end
    check("sat_ready", {31'd0, ready_ok}, 32'd1);
    check("sat_busy", {31'd0, busy}, 32'd0);
    check("sat_issues", issues, 32'd32);
    check("sat_loaded", {26'd0, loaded_cnt}, 32'd32);
    check("sat_drop", {24'd0, drop_cnt}, 32'd2);
    check("sat_cachefull", {31'd0, cacheFull}, 32'd1);

    // Run 127 with eight loads queued behind it: backpressure, then in-order issue
    do_reset();
    mcnt = 0; done_seen = 1'b0;
    push(8'hFF);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h10 + 8'(i);
      @(negedge clk);
      if (mode) mcnt++;
      if (run_done) done_seen = 1'b1;
    end
    in_valid = 1'b0;
    check("bp_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_busy", {31'd0, busy}, 32'd1);
    for (int t = 0; t < 300 && !done_seen; t++) begin
      @(negedge clk);
      if (mode) mcnt++;
      if (run_done) done_seen = 1'b1;
    end
    check("bp_done_seen", {31'd0, done_seen}, 32'd1);
    check("bp_run_len", mcnt, 32'd127);
    got = 0;
    for (int t = 0; t < 40 && got < 8; t++) begin
      @(negedge clk);
      if (mode) mcnt++;
      if (!mode && opCode != 3'd7) begin
        check($sformatf("bp_issue%0d", got), {25'd0, opCode, value}, {25'd0, 3'd1, 4'(got)});
        got++;
      end
    end
    check("bp_issue_count", got, 32'd8);
    check("bp_no_extra_run", mcnt, 32'd127);
    check("bp_loaded", {26'd0, loaded_cnt}, 32'd8);
    check("bp_drained", {30'd0, busy, in_ready}, 32'd1);

    // Reset on the 5th cycle of a 10-cycle run
    do_reset();
    push(8'h05);
    @(negedge clk);
    push(8'h8A);
    for (int t = 0; t < 10 && !mode; t++) @(negedge clk);
    k = mode ? 1 : 0;
    done_seen = run_done;
    for (int t = 0; t < 10 && k < 5; t++) begin
      @(negedge clk);
      if (mode) k++;
      if (run_done) done_seen = 1'b1;
    end
    check("abort_reached", k, 32'd5);
    check("abort_loaded_pre", {26'd0, loaded_cnt}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outs", {23'd0, mode, opCode, value, run_done}, {23'd0, 1'b0, 3'd7, 4'd0, 1'b0});
    check("abort_counts", {10'd0, loaded_cnt, reject_cnt, drop_cnt}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_no_done", {31'd0, done_seen}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_after", {22'd0, in_ready, mode, opCode, value, run_done},
          {22'd0, 1'b1, 1'b0, 3'd7, 4'd0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
